// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one clock-gated ALU among NUM_REQ requesters.
// The ALU enable is raised only while an operation is in flight; idle cycles are counted.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_zero,
  output logic                      alu_enable,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      busy,
  output logic [CNT_W-1:0]          gated_cycles,
  output logic [1:0]                o_dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_owner;
  logic [2:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic [CNT_W-1:0]  r_gated;

  logic              w_found;
  logic [IDX_W-1:0]  w_win;
  logic [IDX_W-1:0]  w_cand;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [OP_W-1:0]   w_op;
  logic              w_grant;
  logic              w_rsp_hs;

  // Handshakes: a request transfers when req_valid[i] && req_ready[i] on a rising edge;
  // a response transfers when rsp_valid[owner] && rsp_ready[owner]. ready never waits on valid
  // of the other channel, and valid, once raised, holds until its transfer.

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_a  = req_a[i*DATA_W +: DATA_W];
        w_b  = req_b[i*DATA_W +: DATA_W];
        w_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  assign w_grant  = (r_state == S_IDLE) && w_found;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready[r_owner];

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_grant && (w_win == IDX_W'(i));
      rsp_valid[i] = (r_state == S_RESP) && (r_owner == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last       <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_lat_cnt    <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_a       <= w_a;
            r_b       <= w_b;
            r_op      <= w_op;
            r_last    <= w_win;
            r_owner   <= w_win;
            r_lat_cnt <= 3'(ALU_LAT - 1);
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_lat_cnt == 3'd0) r_state <= S_CAPTURE;
          else                   r_lat_cnt <= r_lat_cnt - 3'd1;
        end
        S_CAPTURE: begin
          r_rsp_result <= alu_result;
          r_rsp_zero   <= alu_zero;
          r_state      <= S_RESP;
        end
        default: begin
          if (w_rsp_hs) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturates rather than wraps so long idle stretches never read as short ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gated <= '0;
    end else if (!alu_enable && (r_gated != {CNT_W{1'b1}})) begin
      r_gated <= r_gated + 1'b1;
    end
  end

  assign alu_enable   = (r_state == S_ISSUE);
  assign busy         = (r_state != S_IDLE);
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign alu_op       = r_op;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_rsp_zero;
  assign gated_cycles = r_gated;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level model checked every cycle,
// an ALU stand-in, a result scoreboard and directed vectors with literal expectations.
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 4;
  localparam int OP_W    = 3;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 16;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      alu_enable;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [OP_W-1:0]           alu_op;
  logic [DATA_W-1:0]         alu_result;
  logic                      alu_zero;
  logic                      busy;
  logic [CNT_W-1:0]          gated_cycles;
  logic [1:0]                dbg_state;

  // Second instance only exercises counter saturation at a narrow width.
  logic [NUM_REQ-1:0] s_req_ready, s_rsp_valid;
  logic [DATA_W-1:0]  s_rsp_result, s_alu_a, s_alu_b;
  logic [OP_W-1:0]    s_alu_op;
  logic               s_rsp_zero, s_alu_enable, s_busy;
  logic [3:0]         s_gated;
  logic [1:0]         s_dbg_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [DATA_W:0] exp_q[$];
  int              grant_q[$];

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W),
                      .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy),
    .gated_cycles(gated_cycles), .o_dbg_state(dbg_state)
  );

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W),
                      .ALU_LAT(ALU_LAT), .CNT_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .req_valid('0), .req_ready(s_req_ready),
    .req_a('0), .req_b('0), .req_op('0), .rsp_valid(s_rsp_valid),
    .rsp_ready('0), .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero),
    .alu_enable(s_alu_enable), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op),
    .alu_result('0), .alu_zero(1'b0), .busy(s_busy),
    .gated_cycles(s_gated), .o_dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [OP_W-1:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      default: return '0;
    endcase
  endfunction

  // ALU stand-in: registers the result on enabled edges only.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
    end else if (alu_enable) begin
      alu_result <= alu_fn(alu_a, alu_b, alu_op);
      alu_zero   <= (alu_fn(alu_a, alu_b, alu_op) == '0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void rr_pick(input logic [NUM_REQ-1:0] v, input int last,
                                  output bit found, output int win);
    found = 0;
    win   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && v[(last + k) % NUM_REQ]) begin
        found = 1;
        win   = (last + k) % NUM_REQ;
      end
    end
  endfunction

  // ---------------- model + scoreboard ----------------
  bit              m_busy;
  int              m_age, m_owner, m_last, m_gated;
  logic [DATA_W-1:0] m_a, m_b, m_rsp;
  logic [OP_W-1:0]   m_op;
  logic              m_zero;

  always @(negedge clk) begin
    bit found;
    int win;
    bit exp_en;
    logic [NUM_REQ-1:0] exp_rv, exp_rr;
    logic [DATA_W:0] exp_item;
    if (reset) begin
      m_busy = 0; m_age = 0; m_owner = 0; m_last = NUM_REQ - 1; m_gated = 0;
      m_a = '0; m_b = '0; m_op = '0; m_rsp = '0; m_zero = 1'b0;
      exp_q.delete();
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_enable", alu_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_result", {rsp_zero, rsp_result}, 0);
      check("rst_alu_ops", {alu_op, alu_a, alu_b}, 0);
      check("rst_gated", gated_cycles, 0);
    end else begin
      rr_pick(req_valid, m_last, found, win);
      exp_en = m_busy && (m_age >= 1) && (m_age <= ALU_LAT);
      exp_rv = (m_busy && m_age >= ALU_LAT + 2) ? NUM_REQ'(1 << m_owner) : '0;
      exp_rr = (!m_busy && found) ? NUM_REQ'(1 << win) : '0;
      check("mdl_req_ready", req_ready, exp_rr);
      check("mdl_rsp_valid", rsp_valid, exp_rv);
      check("mdl_alu_enable", alu_enable, exp_en);
      check("mdl_busy", busy, m_busy);
      check("mdl_rsp", {rsp_zero, rsp_result}, {m_zero, m_rsp});
      check("mdl_alu_ops", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
      check("mdl_gated", gated_cycles, m_gated);
      if (|(rsp_valid & rsp_ready)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_rsp", rsp_valid & rsp_ready, 0);
        end else begin
          exp_item = exp_q.pop_front();
          check("sb_rsp", {rsp_zero, rsp_result}, exp_item);
        end
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && req_valid[i]) grant_q.push_back(i);
      // Advance to the next cycle.
      if (!exp_en && m_gated < (1 << CNT_W) - 1) m_gated++;
      if (m_busy) begin
        if (m_age == ALU_LAT + 1) begin
          m_rsp  = alu_fn(m_a, m_b, m_op);
          m_zero = (m_rsp == '0);
        end
        if (m_age >= ALU_LAT + 2 && rsp_ready[m_owner]) m_busy = 0;
        else m_age++;
      end else if (found) begin
        m_busy = 1; m_age = 1; m_owner = win; m_last = win;
        m_a  = req_a[win*DATA_W +: DATA_W];
        m_b  = req_b[win*DATA_W +: DATA_W];
        m_op = req_op[win*OP_W +: OP_W];
        exp_q.push_back({alu_fn(m_a, m_b, m_op) == '0, alu_fn(m_a, m_b, m_op)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op);
    req_a[idx*DATA_W +: DATA_W] = a;
    req_b[idx*DATA_W +: DATA_W] = b;
    req_op[idx*OP_W +: OP_W]    = op;
    req_valid[idx]              = 1'b1;
  endtask

  task automatic wait_rsp(input int idx);
    int n = 0;
    while (!rsp_valid[idx] && n < 40) begin
      tick();
      n++;
    end
    check("wait_rsp_valid", rsp_valid[idx], 1);
  endtask

  task automatic do_op(input string name, input int idx, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op,
                       input logic [DATA_W-1:0] exp_res, input logic exp_z);
    int n = 0;
    set_req(idx, a, b, op);
    #1;
    while (!req_ready[idx] && n < 20) begin
      tick();
      n++;
    end
    check({name, "_grant"}, req_ready[idx], 1);
    tick();
    req_valid[idx] = 1'b0;
    wait_rsp(idx);
    check({name, "_result"}, rsp_result, exp_res);
    check({name, "_zero"}, rsp_zero, exp_z);
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready[idx] = 1'b0;
    check({name, "_rsp_drop"}, rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int g0;
    int n;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_op = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset: narrow counter saturates, wide one counts.
    repeat (20) tick();
    check("sat_gated_w4", s_gated, 4'hF);
    check("idle_gated_w16", gated_cycles, 20);
    repeat (3) tick();
    check("sat_gated_hold", s_gated, 4'hF);

    // First operation, cycle by cycle.
    set_req(0, 4'b0101, 4'b0011, 3'b000);
    #1;
    check("c0_req_ready", req_ready, 4'b0001);
    check("c0_alu_enable", alu_enable, 0);
    tick();
    req_valid = '0;
    check("c1_alu_enable", alu_enable, 1);
    check("c1_alu_a", alu_a, 4'b0101);
    tick();
    check("c2_alu_enable", alu_enable, 0);
    check("c2_rsp_valid", rsp_valid, 0);
    tick();
    check("c3_rsp_valid", rsp_valid, 4'b0001);
    check("c3_rsp_result", rsp_result, 4'b1000);
    check("c3_rsp_zero", rsp_zero, 0);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready[0] = 1'b0;
    check("c4_rsp_valid", rsp_valid, 0);
    check("c4_busy", busy, 0);

    do_op("sub2", 2, 4'b1000, 4'b0010, 3'b001, 4'b0110, 1'b0);
    do_op("and2", 2, 4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0);
    do_op("andz2", 2, 4'b1100, 4'b0011, 3'b010, 4'b0000, 1'b1);
    do_op("or1", 1, 4'b1001, 4'b0100, 3'b011, 4'b1101, 1'b0);

    // Response back-pressure on requester 2 with a competing request pending.
    set_req(2, 4'd3, 4'd4, 3'b000);
    #1;
    tick();
    req_valid = '0;
    wait_rsp(2);
    set_req(0, 4'd1, 4'd1, 3'b000);
    g0 = m_gated;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("stall_rsp_valid", rsp_valid, 4'b0100);
      check("stall_rsp_result", rsp_result, 4'd7);
      check("stall_req_ready", req_ready, 0);
      check("stall_alu_enable", alu_enable, 0);
      check("stall_gated", gated_cycles, g0 + k);
    end
    req_valid = '0;
    rsp_ready[2] = 1'b1;
    tick();
    rsp_ready = '0;
    check("stall_release", rsp_valid, 0);

    // Reset during ISSUE, then 0-vs-3 contention.
    set_req(3, 4'd1, 4'd1, 3'b000);
    #1;
    check("rr_after_2", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    check("issue_enable", alu_enable, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_alu_enable", alu_enable, 0);
    check("async_busy", busy, 0);
    check("async_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;
    set_req(0, 4'b1010, 4'b0101, 3'b011);
    set_req(3, 4'd2, 4'd3, 3'b001);
    #1;
    check("post_rst_winner", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_rsp(0);
    check("post_rst_result", rsp_result, 4'b1111);
    rsp_ready[0] = 1'b1;
    tick();
    rsp_ready = '0;

    // Fairness with every requester asking and responses always accepted.
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'(i), 4'd1, 3'b000);
    rsp_ready = '1;
    grant_q.delete();
    n = 0;
    while (grant_q.size() < 5 && n < 80) begin
      tick();
      n++;
    end
    req_valid = '0;
    check("rr_grant_count", grant_q.size() >= 5, 1);
    for (int k = 0; k < 5; k++)
      if (k < grant_q.size()) check("rr_order", grant_q[k], exp_order[k]);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("rr_drain_busy", busy, 0);
    rsp_ready = '0;
    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one clock-gated alu_8bit instance among NUM_REQ requesters.
- Accepts operand/op requests over valid/ready and drives the ALU's enable only while an operation is in flight, so the ALU clock stays gated when idle.
- Captures result/zero and returns them to the granting requester over a valid/ready response channel.
- Counts gated (enable-low) cycles for power reporting.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, ALU operand/result width.
- OP_W, 3, ALU opcode width.
- ALU_LAT, 1, cycles from enabled ALU edge to valid alu_result (1..4).
- CNT_W, 16, width of gated-cycle counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept (one-hot or zero).
- req_a  in  NUM_REQ*DATA_W  flattened operand A; requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  flattened operand B, same packing.
- req_op  in  NUM_REQ*OP_W  flattened opcode; 000 ADD, 001 SUB, 010 AND, 011 OR.
- rsp_valid  out  NUM_REQ  one-hot response valid to the granted requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_result  out  DATA_W  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- alu_enable  out  1  ALU enable / clock-gate control.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  OP_W  ALU opcode.
- alu_result  in  DATA_W  ALU registered result.
- alu_zero  in  1  ALU registered zero flag.
- busy  out  1  high in any state other than IDLE.
- gated_cycles  out  CNT_W  saturating count of cycles with alu_enable=0.

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready, rsp_valid, alu_enable, busy = 0.
  - rsp_result, rsp_zero, alu_a, alu_b, alu_op, gated_cycles = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Winner w = first i with req_valid[i]=1, searching last+1, last+2, ... with wrap modulo NUM_REQ.
  - req_ready[w]=1, combinational from req_valid, only in IDLE; all other req_ready bits 0.
  - On handshake: register w's a/b/op into alu_a/alu_b/alu_op, set last=w, store w as owner, go to ISSUE.
  - With no request: stay in IDLE, alu_enable=0.
- ISSUE:
  - alu_enable=1 for exactly ALU_LAT consecutive cycles, tracked by an internal down-counter.
  - Then go to CAPTURE.
- CAPTURE:
  - alu_enable=0.
  - Sample alu_result/alu_zero into rsp_result/rsp_zero at the end of the cycle.
  - Go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_result/rsp_zero held stable.
  - On rsp_ready[owner]=1: drop rsp_valid next cycle and return to IDLE.
  - rsp_ready of non-owners is ignored.
- No new grant while busy; a request arriving in the handshake cycle of a response waits until IDLE. There is one idle cycle between operations.
- alu_a/alu_b/alu_op hold their last values whenever not in ISSUE, including while gated.
- Timing with ALU_LAT=1: handshake at cycle 0, ISSUE at cycle 1, CAPTURE at cycle 2, rsp_valid from cycle 3.
- busy = (state != IDLE).
- gated_cycles:
  - Increments on every cycle with alu_enable=0, including IDLE, CAPTURE and RESP.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Reset asserted mid-operation:
  - Immediate return to reset values; the in-flight operation is dropped and no response is issued.
  - alu_enable deasserts asynchronously.
- Unsupported opcodes are forwarded unchanged; the result is whatever the ALU returns.

Test Plan:
- Reset, then req_valid[0]=1 with A=0101, B=0011, op=000 -> req_ready[0] at cycle 0; alu_enable=1 only at cycle 1; rsp_valid=0001 at cycle 3 with rsp_result=1000, rsp_zero=0.
- Single ops on requester 2: SUB with A=1000, B=0010 -> 0110. AND with A=1100, B=1010 -> 1000. AND with A=1100, B=0011 -> 0000 and rsp_zero=1.
- All four req_valid held high with rsp_ready tied high -> grant order 0,1,2,3,0; each rsp_valid is one-hot and matches its grant; no requester is granted twice before the others.
- rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_result stable; no req_ready asserted; alu_enable=0; gated_cycles increments by exactly 1 per cycle.
- Reset pulsed during ISSUE -> alu_enable, rsp_valid and busy fall immediately; pointer restarts so requester 0 wins a subsequent 0-vs-3 contention.
- CNT_W=4 with 20 idle cycles after reset -> gated_cycles saturates at 1111 and holds.
